// File: rtl/gfx_pkg.sv
// Shared graphics-pipeline types: fp32 words, Q2.16 fixed point and the
// viewport FSM state encoding.
package gfx_pkg;

    typedef logic [31:0] fp32_t;

    // Signed Q2.16: 1 sign bit, 2 integer bits, 16 fraction bits.
    typedef logic signed [18:0] q16_t;

    localparam int Q16_ONE = 65536;
    localparam int Q16_SAT = 131072;

    typedef enum logic [2:0] {
        VP_IDLE,
        VP_CX,
        VP_CY,
        VP_CZ,
        VP_SCALE,
        VP_DONE
    } vp_state_t;

endpackage

// File: rtl/fp32_to_q16.sv
// Combinational fp32 -> signed Q2.16 converter with out-of-range flag.
// Magnitudes at or above 2.0 (and NaN/Inf) saturate to 2.0; anything
// below 2^-17 (and denormals) flushes to zero.
module fp32_to_q16
    import gfx_pkg::*;
(
    input  fp32_t val,
    output q16_t  q,
    output logic  oor
);

    logic        sign;
    logic [7:0]  expo;
    logic [23:0] sig;
    logic [4:0]  rsh;
    logic [17:0] mag;

    // Decode exponent class, then right-align the significand into Q16.
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default first,
        // so no path through the if/case can leave it holding (a latch).
        sign = val[31];
        expo = val[30:23];
        sig  = {1'b1, val[22:0]};
        rsh  = '0;
        mag  = '0;
        oor  = 1'b0;

        if (expo >= 8'd128) begin
            // |v| >= 2, Inf or NaN (exponent 255 lands here too).
            mag = 18'(Q16_SAT);
            oor = 1'b1;
        end else if (expo < 8'd110) begin
            // Below Q16 resolution, including zero and denormals.
            mag = '0;
        end else begin
            // Exponents 110..127 always need a right shift of 7..24.
            rsh = 5'(8'd134 - expo);
            mag = 18'(sig >> rsh);
            if (mag > 18'(Q16_ONE)) begin
                oor = 1'b1;
            end
        end

        q = sign ? -q16_t'({1'b0, mag}) : q16_t'({1'b0, mag});
    end

endmodule

// File: rtl/viewport_transform.sv
// NDC fp32 vertex -> screen-space pixel x/y, fixed-point depth and clip flag.
// One shared fp32_to_q16 converter is time-multiplexed over x, y, z; a
// final SCALE state maps Q2.16 NDC onto the screen and depth range.
module viewport_transform
    import gfx_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int DEPTH_BITS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  fp32_t                       x,
    input  fp32_t                       y,
    input  fp32_t                       z,
    output logic [$clog2(SCREEN_W)-1:0] px,
    output logic [$clog2(SCREEN_H)-1:0] py,
    output logic [DEPTH_BITS-1:0]       pz,
    output logic                        clipped,
    output logic                        busy,
    output logic                        done
);

    localparam int PX_W = $clog2(SCREEN_W);
    localparam int PY_W = $clog2(SCREEN_H);
    localparam int XP_W = 18 + PX_W + 1;
    localparam int YP_W = 18 + PY_W + 1;
    localparam int PZ_MAX = (1 << DEPTH_BITS) - 1;

    vp_state_t state_q, state_d;
    fp32_t     x_q, x_d, y_q, y_d, z_q, z_d;
    q16_t      xq_q, xq_d, yq_q, yq_d, zq_q, zq_d;
    logic      clip_q, clip_d;
    logic [PX_W-1:0]       px_q, px_d;
    logic [PY_W-1:0]       py_q, py_d;
    logic [DEPTH_BITS-1:0] pz_q, pz_d;
    logic                  clipped_q, clipped_d;

    fp32_t conv_in;
    q16_t  conv_q;
    logic  conv_oor;

    logic signed [19:0] x_off, y_off, z_off;
    logic [17:0]        x_un, y_un, z_un, z_sh;
    logic [XP_W-1:0]    x_prod, x_pix;
    logic [YP_W-1:0]    y_prod, y_pix;
    logic [PX_W-1:0]    px_next;
    logic [PY_W-1:0]    py_next;
    logic [DEPTH_BITS-1:0] pz_next;

    fp32_to_q16 u_conv (
        .val (conv_in),
        .q   (conv_q),
        .oor (conv_oor)
    );

    // Steer the latched coordinate that the current state converts.
    always_comb begin
        conv_in = x_q;
        case (state_q)
            VP_CY:   conv_in = y_q;
            VP_CZ:   conv_in = z_q;
            default: conv_in = x_q;
        endcase
    end

    // Viewport mapping from the registered Q2.16 coordinates; negative
    // intermediates clamp to zero, results clamp to the top of each range.
    always_comb begin
        x_off = $signed({xq_q[18], xq_q}) + 20'sd65536;
        y_off = 20'sd65536 - $signed({yq_q[18], yq_q});
        z_off = $signed({zq_q[18], zq_q}) + 20'sd65536;

        x_un = (x_off < 0) ? '0 : 18'(x_off);
        y_un = (y_off < 0) ? '0 : 18'(y_off);
        z_un = (z_off < 0) ? '0 : 18'(z_off);

        x_prod = XP_W'(x_un) * XP_W'(SCREEN_W);
        y_prod = YP_W'(y_un) * YP_W'(SCREEN_H);
        x_pix  = x_prod >> 17;
        y_pix  = y_prod >> 17;
        z_sh   = z_un >> (17 - DEPTH_BITS);

        px_next = (x_pix > XP_W'(SCREEN_W - 1)) ? PX_W'(SCREEN_W - 1) : PX_W'(x_pix);
        py_next = (y_pix > YP_W'(SCREEN_H - 1)) ? PY_W'(SCREEN_H - 1) : PY_W'(y_pix);
        pz_next = (z_sh > 18'(PZ_MAX)) ? DEPTH_BITS'(PZ_MAX) : DEPTH_BITS'(z_sh);
    end

    // Next-state and datapath-load logic for the conversion sequence.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        xq_d      = xq_q;
        yq_d      = yq_q;
        zq_d      = zq_q;
        clip_d    = clip_q;
        px_d      = px_q;
        py_d      = py_q;
        pz_d      = pz_q;
        clipped_d = clipped_q;

        case (state_q)
            VP_IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    z_d     = z;
                    clip_d  = 1'b0;
                    state_d = VP_CX;
                end
            end
            VP_CX: begin
                xq_d    = conv_q;
                clip_d  = clip_q | conv_oor;
                state_d = VP_CY;
            end
            VP_CY: begin
                yq_d    = conv_q;
                clip_d  = clip_q | conv_oor;
                state_d = VP_CZ;
            end
            VP_CZ: begin
                zq_d    = conv_q;
                clip_d  = clip_q | conv_oor;
                state_d = VP_SCALE;
            end
            VP_SCALE: begin
                px_d      = px_next;
                py_d      = py_next;
                pz_d      = pz_next;
                clipped_d = clip_q;
                state_d   = VP_DONE;
            end
            VP_DONE: begin
                state_d = VP_IDLE;
            end
            default: begin
                state_d = VP_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= VP_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            xq_q      <= '0;
            yq_q      <= '0;
            zq_q      <= '0;
            clip_q    <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            pz_q      <= '0;
            clipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            xq_q      <= xq_d;
            yq_q      <= yq_d;
            zq_q      <= zq_d;
            clip_q    <= clip_d;
            px_q      <= px_d;
            py_q      <= py_d;
            pz_q      <= pz_d;
            clipped_q <= clipped_d;
        end
    end

    assign px      = px_q;
    assign py      = py_q;
    assign pz      = pz_q;
    assign clipped = clipped_q;
    assign busy    = (state_q != VP_IDLE);
    assign done    = (state_q == VP_DONE);

endmodule

// File: tb/tb_viewport_transform.sv
// Self-checking bench for viewport_transform: directed vectors, protocol
// corner cases and randomized vertices against a real-arithmetic model.
module tb_viewport_transform;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] x, y, z;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [15:0] pz;
    logic        clipped, busy, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    viewport_transform #(
        .SCREEN_W   (W),
        .SCREEN_H   (H),
        .DEPTH_BITS (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x       (x),
        .y       (y),
        .z       (z),
        .px      (px),
        .py      (py),
        .pz      (pz),
        .clipped (clipped),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Value of an fp32 word in units of 2^-16, truncated toward zero.
    function automatic void ref_conv(input logic [31:0] f, output longint q, output bit oor);
        int     e;
        longint mag;
        real    v;
        e   = int'(f[30:23]);
        oor = 1'b0;
        if (e >= 128) begin
            mag = 131072;
            oor = 1'b1;
        end else if (e < 110) begin
            mag = 0;
        end else begin
            v   = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127)) * 65536.0;
            mag = longint'($floor(v));
            if (mag > 65536) oor = 1'b1;
        end
        q = f[31] ? -mag : mag;
    endfunction

    function automatic void ref_vertex(input logic [31:0] vx, vy, vz,
                                       output longint epx, epy, epz, output bit eclip);
        longint xq, yq, zq, t;
        bit     ox, oy, oz;
        ref_conv(vx, xq, ox);
        ref_conv(vy, yq, oy);
        ref_conv(vz, zq, oz);
        eclip = ox | oy | oz;
        t = xq + 65536;      if (t < 0) t = 0;
        epx = (t * W) / 131072;   if (epx > W - 1) epx = W - 1;
        t = 65536 - yq;      if (t < 0) t = 0;
        epy = (t * H) / 131072;   if (epy > H - 1) epy = H - 1;
        t = zq + 65536;      if (t < 0) t = 0;
        epz = t / (longint'(1) << (17 - DB));
        if (epz > (longint'(1) << DB) - 1) epz = (longint'(1) << DB) - 1;
    endfunction

    // Issue one vertex and check latency, results and the return to idle.
    // Cycle 0 is the cycle start is high; done is expected in cycle 5.
    task automatic run_vertex(input string tag, input logic [31:0] vx, vy, vz);
        longint epx, epy, epz;
        bit     eclip;
        int     cyc;
        ref_vertex(vx, vy, vz, epx, epy, epz, eclip);
        @(negedge clk);
        start = 1'b1; x = vx; y = vy; z = vz;
        cyc = 0;
        @(negedge clk);
        start = 1'b0; x = $urandom; y = $urandom; z = $urandom;
        cyc = 1;
        check({tag, " busy"}, 64'(busy), 64'd1);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'd5);
        check({tag, " px"}, 64'(px), 64'(epx));
        check({tag, " py"}, 64'(py), 64'(epy));
        check({tag, " pz"}, 64'(pz), 64'(epz));
        check({tag, " clipped"}, 64'(clipped), 64'(eclip));
        check({tag, " busy_in_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({tag, " done_1cyc"}, 64'(done), 64'd0);
        check({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rand_fp32();
        int          sel;
        logic [7:0]  e;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = 8'($urandom_range(100, 109));
            default: e = 8'($urandom_range(110, 129));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        longint epx, epy, epz;
        bit     eclip;
        int     n_done;
        int     cyc;

        reset = 1'b1; start = 1'b0; x = '0; y = '0; z = '0;
        repeat (2) @(negedge clk);
        check("rst px", 64'(px), 64'd0);
        check("rst py", 64'(py), 64'd0);
        check("rst pz", 64'(pz), 64'd0);
        check("rst clipped", 64'(clipped), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // Directed vectors from the plan; the model must agree with the
        // hand-derived numbers, so check those too.
        ref_vertex(32'h3f000000, 32'hbf000000, 32'h00000000, epx, epy, epz, eclip);
        check("model half px", 64'(epx), 64'd480);
        check("model half py", 64'(epy), 64'd360);
        check("model half pz", 64'(epz), 64'd32768);
        run_vertex("half", 32'h3f000000, 32'hbf000000, 32'h00000000);
        run_vertex("corner", 32'hbf800000, 32'h3f800000, 32'h3f800000);
        run_vertex("clip_x", 32'h3fc00000, 32'h00000000, 32'h00000000);
        run_vertex("clip_clear", 32'h3f000000, 32'hbf000000, 32'h00000000);
        run_vertex("nan", 32'h7fc00000, 32'h00000000, 32'h33d6bf95);

        // Second start two cycles in is ignored: one done, first vertex's results.
        ref_vertex(32'h3e800000, 32'h3e800000, 32'hbe800000, epx, epy, epz, eclip);
        @(negedge clk);
        start = 1'b1; x = 32'h3e800000; y = 32'h3e800000; z = 32'hbe800000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; x = 32'hbf400000; y = 32'hbf400000; z = 32'h3f400000;
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                n_done++;
                check("dbl px", 64'(px), 64'(epx));
                check("dbl py", 64'(py), 64'(epy));
                check("dbl pz", 64'(pz), 64'(epz));
            end
            @(negedge clk);
        end
        check("dbl done_count", 64'(n_done), 64'd1);

        // Start during the DONE cycle is dropped.
        ref_vertex(32'hbe800000, 32'h3f000000, 32'h3f000000, epx, epy, epz, eclip);
        @(negedge clk);
        start = 1'b1; x = 32'hbe800000; y = 32'h3f000000; z = 32'h3f000000;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("drop latency", 64'(cyc), 64'd5);
        start = 1'b1; x = 32'h3f800000; y = 32'h3f800000; z = 32'h3f800000;
        @(negedge clk);
        start = 1'b0;
        check("drop idle", 64'(busy), 64'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("drop no_done", 64'(n_done), 64'd0);
        check("drop px_held", 64'(px), 64'(epx));

        // Reset while in CY aborts the vertex with no done.
        @(negedge clk);
        start = 1'b1; x = 32'h3f000000; y = 32'h3f000000; z = 32'h3f000000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort px", 64'(px), 64'd0);
        check("abort py", 64'(py), 64'd0);
        check("abort pz", 64'(pz), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort no_done", 64'(n_done), 64'd0);
        run_vertex("after_abort", 32'h3f000000, 32'hbf000000, 32'h00000000);

        // Randomized vertices with occasional idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_vertex($sformatf("rand%0d", i), rand_fp32(), rand_fp32(), rand_fp32());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/viewport_transform.md
# viewport_transform

Converts one transformed vertex from `matrix_multiply` into integer screen-space coordinates. Input is fp32 normalized-device x/y/z. Output is pixel x/y, a fixed-point depth value, and a clip flag. It sits directly downstream of `matrix_multiply`, with `x_out/y_out/z_out/done` wired to `x/y/z/start`, and feeds the rasterizer. It uses a multi-cycle FSM with one shared fp32-to-fixed converter, so no floating-point multipliers are needed.

## Interface
- `SCREEN_W`, default 640: screen width in pixels.
- `SCREEN_H`, default 480: screen height in pixels.
- `DEPTH_BITS`, default 16: depth output width, must be ≤ 17.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; one clock, and the reset polarity and synchronicity are fixed.
- `start` in 1: one-cycle pulse; x/y/z are valid on the same cycle.
- `x`, `y`, `z` in 32 each: IEEE-754 fp32 NDC coordinates.
- `px` out $clog2(SCREEN_W): pixel column.
- `py` out $clog2(SCREEN_H): pixel row, 0 = top.
- `pz` out DEPTH_BITS: depth, 0 = near (z = −1).
- `clipped` out 1: any coordinate had magnitude > 1.0, or was NaN/Inf.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when px/py/pz/clipped are updated.

## Operation
- **FSM states:** IDLE → CX → CY → CZ → SCALE → DONE → IDLE.
- **IDLE:** on `start`, register x/y/z and go to CX. `start` is ignored in all other states.
- **CX, CY, CZ:** each feeds one latched value through `fp32_to_q16` and registers the signed Q2.16 result (xq, yq, zq). Each state ORs that value's out-of-range flag into a clip accumulator, which is cleared on entry to CX.
- **fp32_to_q16 conversion** (s = sign, e = exponent, m = mantissa):
  - e == 255 (NaN/Inf): magnitude = 131072, oor = 1.
  - e ≥ 128 (|v| ≥ 2): magnitude = 131072, oor = 1.
  - e < 110, or e == 0 (denormal): magnitude = 0.
  - Otherwise: magnitude = (2^23 | m) shifted by (e − 134). Shift left if positive, right if negative; truncate toward zero.
  - oor is also set when magnitude > 65536.
  - Result = s ? −magnitude : magnitude. −0 gives 0.
- **SCALE:** compute and register all outputs; `clipped` = accumulator.
  - px = min(SCREEN_W−1, ((xq + 65536) · SCREEN_W) >> 17).
  - py = min(SCREEN_H−1, ((65536 − yq) · SCREEN_H) >> 17).
  - pz = min(2^DEPTH_BITS − 1, (zq + 65536) >> (17 − DEPTH_BITS)).
  - Any intermediate below 0 clamps to 0 before the shift.
- **DONE:** `done` = 1 for this cycle only, then go to IDLE.
- Outputs hold their last value until the next SCALE.

## Timing
- Reset values: state = IDLE; px = py = pz = 0; clipped = 0; done = 0; busy = 0.
- `start` sampled at edge N → `busy` high after edge N.
- Outputs are valid after edge N+4 and `done` is high during cycle N+5. That is 5 clocks from start to done.
- `done` and `busy` are both high during the DONE cycle.
- `start` during the DONE cycle is dropped. The earliest accepted restart is the cycle after `done`, so throughput is 1 vertex per 6 clocks.
- Reset mid-operation: FSM returns to IDLE, outputs go to reset values, and no `done` pulse is produced for the aborted vertex.
- Intermediate widths:
  - (xq + 65536) is an 18-bit unsigned value; its product with SCREEN_W needs 18 + $clog2(SCREEN_W) + 1 bits.
  - Keep signed arithmetic for yq and zq.

## Structure
- Shared package `gfx_pkg` holds:
  - `typedef logic [31:0] fp32_t`.
  - The Q2.16 typedef (19-bit signed).
  - `localparam Q16_ONE = 65536` and `Q16_SAT = 131072`.
  - The `vp_state_t` enum.
- Sub-module `fp32_to_q16`: combinational; input fp32_t; outputs Q2.16 value and oor. It is reused later by the rasterizer setup.

## Test plan
- Defaults; x = 3f000000 (0.5), y = bf000000 (−0.5), z = 00000000 → px = 480, py = 360, pz = 32768, clipped = 0, `done` exactly 5 clocks after `start`.
- x = bf800000 (−1), y = 3f800000 (1), z = 3f800000 (1) → px = 0, py = 0, pz = 65535 (clamped), clipped = 0.
- x = 3fc00000 (1.5), y = 0, z = 0 → px = 639, py = 240, pz = 32768, clipped = 1. Next vertex (0.5, −0.5, 0) → clipped = 0 (accumulator cleared).
- x = 7fc00000 (NaN), y = 0, z = 33d6bf95 (1e-7) → clipped = 1, px = 639, pz = 32768 (tiny value flushes to 0).
- Second `start` pulse 2 cycles after the first → ignored; exactly one `done`, with the first vertex's results.
- Assert `reset` in state CY → no `done`; px = py = pz = 0, busy = 0 next cycle. A fresh `start` then completes normally.
